// File: rtl/bp_bimodal.sv
// -----------------------------------------------------------------------------
// bp_bimodal
//   Direct-mapped bimodal branch predictor. Each entry holds a valid bit, a
//   2-bit saturating counter and a branch target. The table is trained from
//   the execute-unit resolution stream. It serves one registered lookup per
//   cycle to fetch.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   ifu_lookup_vld      fetch wants a prediction for ifu_bp_idx this cycle
//   ifu_bp_idx          lookup index
//   bp_pred_vld         registered: lookup result valid
//   bp_pred_taken       registered: predict taken
//   bp_pred_target      registered: predicted target (0 when not taken)
//   exu_bp_strobe       a branch resolved this cycle
//   instr_tag_exu_in    table index of the resolved branch
//   exu_br_dir          resolved direction (1 = taken)
//   exu_pc_in           resolved target, used only when taken
//   bp_clear            synchronous flush of the whole table
// -----------------------------------------------------------------------------
module bp_bimodal #(
    parameter int          XLEN         = 32,
    parameter int          BP_ADDR_SIZE = 6,
    parameter logic [1:0]  CTR_RESET    = 2'b01
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ifu_lookup_vld,
    input  logic [BP_ADDR_SIZE-1:0] ifu_bp_idx,
    output logic                    bp_pred_vld,
    output logic                    bp_pred_taken,
    output logic [XLEN-1:0]         bp_pred_target,
    input  logic                    exu_bp_strobe,
    input  logic [BP_ADDR_SIZE-1:0] instr_tag_exu_in,
    input  logic                    exu_br_dir,
    input  logic [XLEN-1:0]         exu_pc_in,
    input  logic                    bp_clear
);

    localparam int N = 1 << BP_ADDR_SIZE;

    // Valid and counter state sits in flops so that a clear is a single cycle.
    logic [N-1:0]       valid_q, valid_d;
    logic [N-1:0][1:0]  ctr_q,   ctr_d;
    // Targets carry no reset: a target is only read once its entry is valid.
    logic [XLEN-1:0]    tgt_q [N];

    logic               upd_en;
    logic               tgt_we;
    logic [1:0]         cur_ctr;
    logic [1:0]         upd_ctr;

    logic               pred_vld_q,   pred_vld_d;
    logic               pred_taken_q, pred_taken_d;
    logic [XLEN-1:0]    pred_tgt_q,   pred_tgt_d;

    // A clear wins over a same-cycle update, and the update is dropped.
    assign upd_en  = exu_bp_strobe & ~bp_clear;
    assign tgt_we  = upd_en & exu_br_dir;
    assign cur_ctr = ctr_q[instr_tag_exu_in];

    // Counter value after an update. An invalid entry allocates to weakly-taken
    // or to CTR_RESET. A valid entry saturates at 0 and 3.
    always_comb begin
        upd_ctr = cur_ctr;
        if (!valid_q[instr_tag_exu_in]) begin
            upd_ctr = exu_br_dir ? 2'b10 : CTR_RESET;
        end else if (exu_br_dir) begin
            upd_ctr = (cur_ctr == 2'b11) ? cur_ctr : cur_ctr + 2'd1;
        end else begin
            upd_ctr = (cur_ctr == 2'b00) ? cur_ctr : cur_ctr - 2'd1;
        end
    end

    // Next table state. The lookup below reads this, not the flops, so a
    // same-cycle update or clear is visible to the lookup (write-through).
    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        if (bp_clear) begin
            valid_d = '0;
            for (int i = 0; i < N; i++) ctr_d[i] = CTR_RESET;
        end else if (upd_en) begin
            valid_d[instr_tag_exu_in] = 1'b1;
            ctr_d[instr_tag_exu_in]   = upd_ctr;
        end
    end

    always_comb begin
        pred_vld_d   = ifu_lookup_vld;
        pred_taken_d = ifu_lookup_vld & valid_d[ifu_bp_idx] & ctr_d[ifu_bp_idx][1];
        pred_tgt_d   = '0;
        if (pred_taken_d) begin
            pred_tgt_d = (tgt_we && instr_tag_exu_in == ifu_bp_idx) ? exu_pc_in
                                                                     : tgt_q[ifu_bp_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) ctr_q[i] <= CTR_RESET;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tgt_we) tgt_q[instr_tag_exu_in] <= exu_pc_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_vld_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_tgt_q   <= '0;
        end else begin
            pred_vld_q   <= pred_vld_d;
            pred_taken_q <= pred_taken_d;
            pred_tgt_q   <= pred_tgt_d;
        end
    end

    assign bp_pred_vld    = pred_vld_q;
    assign bp_pred_taken  = pred_taken_q;
    assign bp_pred_target = pred_tgt_q;

endmodule

// File: tb/tb_bp_bimodal.sv
module tb_bp_bimodal;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_lookup_vld = 1'b0;
    logic [5:0]  ifu_bp_idx = '0;
    logic        bp_pred_vld;
    logic        bp_pred_taken;
    logic [31:0] bp_pred_target;
    logic        exu_bp_strobe = 1'b0;
    logic [5:0]  instr_tag_exu_in = '0;
    logic        exu_br_dir = 1'b0;
    logic [31:0] exu_pc_in = '0;
    logic        bp_clear = 1'b0;

    bp_bimodal #(.XLEN(32), .BP_ADDR_SIZE(6), .CTR_RESET(2'b01)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_lookup_vld(ifu_lookup_vld), .ifu_bp_idx(ifu_bp_idx),
        .bp_pred_vld(bp_pred_vld), .bp_pred_taken(bp_pred_taken),
        .bp_pred_target(bp_pred_target),
        .exu_bp_strobe(exu_bp_strobe), .instr_tag_exu_in(instr_tag_exu_in),
        .exu_br_dir(exu_br_dir), .exu_pc_in(exu_pc_in), .bp_clear(bp_clear)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: per-entry valid flag, integer counter 0..3, target.
    bit          m_valid [64];
    int          m_ctr   [64];
    logic [31:0] m_tgt   [64];
    bit          m_vld, m_taken;
    logic [31:0] m_target;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
            m_tgt[i]   = '0;
        end
    endtask

    task automatic model_cycle(input bit lk, input int idx, input bit st, input int tag,
                               input bit dir, input logic [31:0] pc, input bit clr);
        if (clr) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
        end else if (st) begin
            if (!m_valid[tag]) begin
                m_valid[tag] = 1;
                m_ctr[tag]   = dir ? 2 : 1;
            end else if (dir) begin
                m_ctr[tag] = (m_ctr[tag] + 1 > 3) ? 3 : m_ctr[tag] + 1;
            end else begin
                m_ctr[tag] = (m_ctr[tag] - 1 < 0) ? 0 : m_ctr[tag] - 1;
            end
            if (dir) m_tgt[tag] = pc;
        end
        m_vld    = lk;
        m_taken  = lk && m_valid[idx] && (m_ctr[idx] >= 2);
        m_target = m_taken ? m_tgt[idx] : 32'h0;
    endtask

    // Drive one cycle of stimulus starting from a negedge. Inputs that must be
    // ignored are filled with junk, and the model advances with the same cycle.
    task automatic apply(input bit lk, input logic [5:0] idx, input bit st,
                         input logic [5:0] tag, input bit dir, input logic [31:0] pc,
                         input bit clr);
        ifu_lookup_vld   = lk;
        ifu_bp_idx       = lk ? idx : 6'($urandom);
        exu_bp_strobe    = st;
        instr_tag_exu_in = st ? tag : 6'($urandom);
        exu_br_dir       = st ? dir : 1'($urandom);
        exu_pc_in        = (st && dir) ? pc : $urandom;
        bp_clear         = clr;
        model_cycle(lk, int'(idx), st, int'(tag), dir, pc, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit ev, input bit et, input logic [31:0] etgt);
        n_vec++;
        if (bp_pred_vld !== ev || bp_pred_taken !== et || bp_pred_target !== etgt) begin
            n_miss++;
            $display("FAIL %s: got vld=%b taken=%b tgt=%h, want vld=%b taken=%b tgt=%h",
                     name, bp_pred_vld, bp_pred_taken, bp_pred_target, ev, et, etgt);
        end
    endtask

    typedef struct {
        bit          lk;
        logic [5:0]  idx;
        bit          st;
        logic [5:0]  tag;
        bit          dir;
        logic [31:0] pc;
        bit          clr;
        bit          e_vld;
        bit          e_taken;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(bit lk, int idx, bit st, int tag, bit dir, logic [31:0] pc,
                                bit clr, bit ev, bit et, logic [31:0] etgt);
        vec_t v;
        v.lk = lk; v.idx = 6'(idx); v.st = st; v.tag = 6'(tag); v.dir = dir; v.pc = pc;
        v.clr = clr; v.e_vld = ev; v.e_taken = et; v.e_tgt = etgt;
        return v;
    endfunction

    initial begin
        model_reset();
        //          lk idx st tag dir pc            clr  vld tk target
        vt.push_back(mk(1, 5, 0, 0, 0, 32'h0,      0,   1, 0, 32'h0));   // empty table
        vt.push_back(mk(0, 0, 1, 5, 1, 32'h100,    0,   0, 0, 32'h0));   // allocate taken
        vt.push_back(mk(1, 5, 0, 0, 0, 32'h0,      0,   1, 1, 32'h100)); // ctr 2
        vt.push_back(mk(1, 5, 1, 5, 1, 32'h104,    0,   1, 1, 32'h104)); // ctr 3, bypass
        vt.push_back(mk(0, 0, 1, 5, 1, 32'h104,    0,   0, 0, 32'h0));   // stays 3
        vt.push_back(mk(1, 5, 0, 0, 0, 32'h0,      0,   1, 1, 32'h104));
        vt.push_back(mk(1, 5, 1, 5, 0, 32'hdead,   0,   1, 1, 32'h104)); // ctr 2
        vt.push_back(mk(1, 5, 1, 5, 0, 32'hbeef,   0,   1, 0, 32'h0));   // ctr 1
        vt.push_back(mk(1, 5, 1, 5, 0, 32'h0,      0,   1, 0, 32'h0));   // ctr 0
        vt.push_back(mk(1, 5, 1, 5, 0, 32'h0,      0,   1, 0, 32'h0));   // stays 0
        vt.push_back(mk(1, 5, 1, 5, 1, 32'h108,    0,   1, 0, 32'h0));   // ctr 1: no wrap
        vt.push_back(mk(1, 5, 1, 5, 1, 32'h10c,    0,   1, 1, 32'h10c)); // ctr 2
        vt.push_back(mk(1, 9, 1, 9, 1, 32'h200,    0,   1, 1, 32'h200)); // allocate bypass
        vt.push_back(mk(1, 4, 1, 3, 1, 32'h300,    0,   1, 0, 32'h0));   // other idx unaffected
        vt.push_back(mk(1, 3, 0, 0, 0, 32'h0,      0,   1, 1, 32'h300));
        vt.push_back(mk(0, 0, 1, 1, 1, 32'h11,     0,   0, 0, 32'h0));
        vt.push_back(mk(0, 0, 1, 2, 1, 32'h22,     0,   0, 0, 32'h0));
        vt.push_back(mk(1, 63, 1, 63, 1, 32'h3f0,  0,   1, 1, 32'h3f0));
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,      0,   1, 1, 32'h11));
        vt.push_back(mk(1, 1, 1, 1, 1, 32'h999,    1,   1, 0, 32'h0));   // clear beats update
        vt.push_back(mk(1, 2, 0, 0, 0, 32'h0,      0,   1, 0, 32'h0));
        vt.push_back(mk(1, 63, 0, 0, 0, 32'h0,     0,   1, 0, 32'h0));
        vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,      0,   1, 0, 32'h0));   // dropped update
        vt.push_back(mk(1, 2, 1, 2, 0, 32'h0,      0,   1, 0, 32'h0));   // alloc not-taken, ctr 1
        vt.push_back(mk(1, 2, 1, 2, 1, 32'h44,     0,   1, 1, 32'h44));  // ctr 2
        vt.push_back(mk(1, 9, 0, 0, 0, 32'h0,      0,   1, 0, 32'h0));   // cleared earlier

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            apply(vt[i].lk, vt[i].idx, vt[i].st, vt[i].tag, vt[i].dir, vt[i].pc, vt[i].clr);
            check($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_taken, vt[i].e_tgt);
            @(negedge clk);
        end

        // Async reset between edges while a lookup and an update are pending.
        apply(1, 6'd7, 1, 6'd7, 1, 32'h70, 0);
        check("pre_reset_train", 1'b1, 1'b1, 32'h70);
        @(negedge clk);
        ifu_lookup_vld = 1'b1; ifu_bp_idx = 6'd7;
        exu_bp_strobe = 1'b1; instr_tag_exu_in = 6'd7; exu_br_dir = 1'b1; exu_pc_in = 32'h74;
        #2 rst_n = 1'b0;
        #1 check("async_reset_immediate", 1'b0, 1'b0, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 6'd7, 0, 6'd0, 0, 32'h0, 0);
        check("post_reset_lookup", 1'b1, 1'b0, 32'h0);
        @(negedge clk);

        // Randomized traffic on a small index set for frequent collisions.
        for (int n = 0; n < 600; n++) begin
            logic [5:0] ri, rt;
            ri = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            rt = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            apply(1'($urandom_range(0, 3) != 0), ri, 1'($urandom_range(0, 2) != 0), rt,
                  1'($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 49) == 0));
            check($sformatf("rand%0d", n), m_vld, m_taken, m_target);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bp_bimodal.md
Name: bp_bimodal

Overview:
- Direct-mapped bimodal branch predictor with 2-bit saturating counters and a stored target per entry.
- Sits downstream of the execute unit. It consumes the EXU branch-resolution stream (`instr_tag_exu_out`, `exu_br_dir`, `exu_pc_out`, `exu_bp_strobe`) to train the table.
- Serves registered prediction lookups to the fetch stage.

Parameters:
- XLEN, 32, datapath and PC width.
- BP_ADDR_SIZE, 6, table index width; the table holds 2**BP_ADDR_SIZE entries.
- CTR_RESET, 2'b01, counter value loaded at reset, on clear, and on not-taken allocation.

Ports:
- clk  input  1  core clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- ifu_lookup_vld  input  1  fetch requests a prediction this cycle.
- ifu_bp_idx  input  BP_ADDR_SIZE  lookup index (same encoding as the EXU instr tag).
- bp_pred_vld  output  1  registered: lookup result valid.
- bp_pred_taken  output  1  registered: predict taken.
- bp_pred_target  output  XLEN  registered: predicted target; 0 when not taken.
- exu_bp_strobe  input  1  a branch resolved this cycle.
- instr_tag_exu_in  input  BP_ADDR_SIZE  index of the resolved branch.
- exu_br_dir  input  1  resolved direction (1 = taken).
- exu_pc_in  input  XLEN  resolved target; meaningful only when exu_br_dir = 1.
- bp_clear  input  1  synchronous flush of the whole table.

Behaviour:
- Entry storage: valid (1 bit), ctr (2 bits), target (XLEN bits).
  - Valid and ctr live in flops so they can be cleared in one cycle.
  - Target may be flop or RAM-style; it is never read while valid = 0.
- Reset (asynchronous, rst_n = 0):
  - Every entry: valid = 0, ctr = CTR_RESET.
  - Outputs: bp_pred_vld = 0, bp_pred_taken = 0, bp_pred_target = 0.
  - Reset asserted mid-operation discards any in-flight lookup or update; the first cycle after deassertion sees an empty table.
- Lookup (latency 1 cycle):
  - At the clock edge where ifu_lookup_vld = 1, register `bp_pred_vld = 1`.
  - Register `bp_pred_taken = valid[idx] & ctr[idx][1]`.
  - Register `bp_pred_target = bp_pred_taken ? target[idx] : 0`.
  - If ifu_lookup_vld = 0: bp_pred_vld = 0 next cycle; taken and target also go to 0.
- Update, applied at the edge where exu_bp_strobe = 1, to entry e = instr_tag_exu_in:
  - If e is invalid (allocate): valid = 1.
    - dir = 1: ctr = 2'b10, target = exu_pc_in.
    - dir = 0: ctr = CTR_RESET; target unchanged.
  - If e is valid:
    - dir = 1: ctr = min(ctr+1, 2'b11), target = exu_pc_in.
    - dir = 0: ctr = max(ctr-1, 2'b00); target unchanged.
  - Counters saturate at 3 and 0; no wrap-around.
- Same-cycle lookup and update to the same index: the lookup returns the post-update state (write-through bypass).
  - Taken and target are computed from the new valid, ctr and target values.
  - A lookup and update to different indices proceed independently.
- bp_clear = 1: at the edge, all entries get valid = 0, ctr = CTR_RESET.
  - Clear has priority over a same-cycle update; the update is dropped.
  - A lookup in the same cycle as clear returns bp_pred_taken = 0 (bypass sees the cleared state). bp_pred_vld still follows ifu_lookup_vld.
- X safety: exu_pc_in, instr_tag_exu_in and exu_br_dir are ignored when exu_bp_strobe = 0. ifu_bp_idx is ignored when ifu_lookup_vld = 0.
- No backpressure: one update per cycle and one lookup per cycle are always accepted.

Test Plan:
- Reset then lookup idx 5 → next cycle: vld = 1, taken = 0, target = 0.
- Update idx 5, dir = 1, pc = 0x100 (allocate) → lookup idx 5: taken = 1, target = 0x100, ctr = 2'b10. A second taken update with pc = 0x104 gives ctr = 3, target = 0x104. A third taken update leaves ctr = 3 (saturates).
- Hysteresis on idx 5 from ctr = 3:
  - One not-taken update → ctr = 2, still predicts taken with target 0x104.
  - Second not-taken update → ctr = 1, predicts not taken with target = 0.
  - Two more not-taken updates → ctr = 0 (saturates).
- Same-cycle lookup and update, idx 9 invalid, dir = 1, pc = 0x200 → lookup result: taken = 1, target = 0x200 (bypass). In the same cycle, an update to idx 3 with a lookup of idx 4 leaves idx 4 unaffected.
- Populate idx 1, 2 and 63 as taken, then assert bp_clear together with an update to idx 1 (dir = 1) → subsequent lookups of idx 1, 2 and 63 all give taken = 0. Idx 63 checks the top-of-table wrap boundary.
- Assert rst_n low asynchronously, between clock edges, while strobe and lookup are active → outputs go to 0 immediately; after release, a lookup of a previously trained index returns taken = 0.
